alu_slice_sequencer: RTL

- Multi-cycle initiator that drives the 8-bit datapath ALU (ADD/AND/OR, carry-in, CZN flags out) to execute operations wider than 8 bits, one byte slice per cycle, low slice first.
- Sits between the control unit / register file and the ALU.
- Takes a wide operation through a start/ready handshake and returns a registered result plus its own C, Z and N flags.

---
 rtl/alu_slice_sequencer_if.sv | 25 ++
 rtl/alu_slice_sequencer.sv | 122 ++++++++++++
 2 files changed

// File: rtl/alu_slice_sequencer_if.sv
// Request/response bus between the control unit (master) and the
// slice sequencer (slave): start/ready handshake, wide operands, registered result.
interface alu_slice_sequencer_if #(
  parameter int W = 16
);
  logic         start;
  logic         ready;
  logic [1:0]   op;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         carry_in;
  logic [W-1:0] result;
  logic [2:0]   flags;
  logic         done;

  modport master (
    output start, op, a_in, b_in, carry_in,
    input  ready, result, flags, done
  );

  modport slave (
    input  start, op, a_in, b_in, carry_in,
    output ready, result, flags, done
  );
endinterface

// File: rtl/alu_slice_sequencer.sv
// Runs a W-bit ADD/AND/OR through the 8-bit datapath ALU one byte slice per
// cycle, low slice first, chaining the carry and producing its own {N,Z,C}.
module alu_slice_sequencer #(
  parameter int         NSLICE = 2,
  parameter logic [1:0] OP_ADD = 2'b00,
  parameter logic [1:0] OP_AND = 2'b01,
  parameter logic [1:0] OP_OR  = 2'b10
) (
  input  logic                 clk,
  input  logic                 rst,
  alu_slice_sequencer_if.slave bus,
  output logic [7:0]           alu_a,
  output logic [7:0]           alu_b,
  output logic [1:0]           alu_op,
  output logic                 alu_c,
  input  logic [7:0]           alu_result,
  input  logic [2:0]           alu_czn
);

  localparam int CW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t                   state;
  state_t                   state_next;
  logic [CW-1:0]            slice;
  logic [NSLICE-1:0][7:0]   a_q;
  logic [NSLICE-1:0][7:0]   b_q;
  logic [NSLICE-1:0][7:0]   stage;
  logic [NSLICE-1:0][7:0]   full;
  logic [1:0]               op_q;
  logic                     cin_q;
  logic                     carry_q;
  logic                     last_slice;
  logic                     is_add;
  logic                     is_legal;
  logic                     carry_out;
  wire  [1:0]               czn_unused = alu_czn[2:1];

  assign last_slice = (slice == LAST);
  assign is_add     = (op_q == OP_ADD);
  assign is_legal   = (op_q == OP_ADD) || (op_q == OP_AND) || (op_q == OP_OR);
  assign carry_out  = is_add & alu_czn[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = RUN;
      RUN:     if (last_slice) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Staged result with the slice currently on the ALU merged in; on the
  // last slice this is the complete W-bit result.
  always_comb begin
    full        = stage;
    full[slice] = alu_result;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slice      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= OP_ADD;
      cin_q      <= 1'b0;
      carry_q    <= 1'b0;
      stage      <= '0;
      bus.result <= '0;
      bus.flags  <= 3'b000;
    end else if (state == IDLE) begin
      if (bus.start) begin
        a_q   <= bus.a_in;
        b_q   <= bus.b_in;
        op_q  <= bus.op;
        cin_q <= bus.carry_in;
        slice <= '0;
      end
    end else if (state == RUN) begin
      stage   <= full;
      carry_q <= carry_out;
      if (last_slice) begin
        bus.result <= full;
        bus.flags  <= {full[NSLICE-1][7], (full == '0), carry_out};
      end else begin
        slice <= slice + 1'b1;
      end
    end
  end

  // An illegal opcode runs as AND against zero so the result is always 0.
  always_comb begin
    bus.ready = (state == IDLE);
    bus.done  = (state == DONE);
    alu_a     = 8'h00;
    alu_b     = 8'h00;
    alu_op    = OP_ADD;
    alu_c     = 1'b0;
    if (state == RUN) begin
      alu_a  = a_q[slice];
      alu_b  = is_legal ? b_q[slice] : 8'h00;
      alu_op = is_legal ? op_q : OP_AND;
      alu_c  = is_add & ((slice == '0) ? cin_q : carry_q);
    end
  end

endmodule
